// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the two-port SRAM arbiter.
// The round-robin option is selected by RAM_ARB_RR_EN (see ram_arb_pick).
package ram_arb_pkg;

    localparam int unsigned RAM_ARB_CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        STROBE,
        HOLD
    } ram_arb_state_t;

    typedef enum logic {
        PORT_A,
        PORT_B
    } ram_arb_port_t;

endpackage

// File: rtl/ram_arb_pick.sv
// Grant selection for the SRAM arbiter.
// RAM_ARB_RR_EN defined: round-robin on contention; undefined: port A has fixed priority.
module ram_arb_pick
    import ram_arb_pkg::*;
(
    input  logic          a_req,
    input  logic          b_req,
    input  ram_arb_port_t rr_last,
    output logic          grant_valid,
    output ram_arb_port_t grant_port
);

    assign grant_valid = a_req | b_req;

`ifdef RAM_ARB_RR_EN
    always_comb begin
        if (a_req && b_req) begin
            grant_port = (rr_last == PORT_A) ? PORT_B : PORT_A;
        end else if (a_req) begin
            grant_port = PORT_A;
        end else begin
            grant_port = PORT_B;
        end
    end
`else
    logic unused_rr_last;
    assign unused_rr_last = rr_last;
    assign grant_port     = a_req ? PORT_A : PORT_B;
`endif

endmodule

// File: rtl/ram_arbiter.sv
// Two-port arbiter and strobe sequencer for an asynchronous SRAM with active-low CS/WE/OE.
// Build option RAM_ARB_RR_EN enables round-robin arbitration (default: fixed priority to A).
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int unsigned AW          = 16,
    parameter int unsigned DW          = 8,
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          a_req,
    input  logic          a_we,
    input  logic [AW-1:0] a_addr,
    input  logic [DW-1:0] a_wdata,
    output logic          a_ack,
    output logic [DW-1:0] a_rdata,
    input  logic          b_req,
    input  logic          b_we,
    input  logic [AW-1:0] b_addr,
    input  logic [DW-1:0] b_wdata,
    output logic          b_ack,
    output logic [DW-1:0] b_rdata,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_dout,
    output logic          ram_doe,
    input  logic [DW-1:0] ram_din,
    output logic          ram_cs_n,
    output logic          ram_we_n,
    output logic          ram_oe_n,
    output logic          busy
);

    localparam logic [RAM_ARB_CNT_W-1:0] LAST_CNT = RAM_ARB_CNT_W'(WAIT_STATES);

    ram_arb_state_t           state_q, state_d;
    logic [RAM_ARB_CNT_W-1:0] cnt_q, cnt_d;
    ram_arb_port_t            winner_q, winner_d;
    logic                     wr_q, wr_d;
    logic [AW-1:0]            addr_q, addr_d;
    logic [DW-1:0]            dout_q, dout_d;
    logic                     doe_q, doe_d;
    logic                     cs_n_q, cs_n_d;
    logic                     we_n_q, we_n_d;
    logic                     oe_n_q, oe_n_d;
    logic                     a_ack_q, a_ack_d;
    logic                     b_ack_q, b_ack_d;
    logic [DW-1:0]            a_rdata_q, a_rdata_d;
    logic [DW-1:0]            b_rdata_q, b_rdata_d;

    logic          grant_valid;
    ram_arb_port_t grant_port;
    ram_arb_port_t rr_last;
    logic          sel_we;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_wdata;

`ifdef RAM_ARB_RR_EN
    ram_arb_port_t rr_q, rr_d;
    assign rr_last = rr_q;
`else
    assign rr_last = PORT_B;
`endif

    ram_arb_pick u_pick (
        .a_req       (a_req),
        .b_req       (b_req),
        .rr_last     (rr_last),
        .grant_valid (grant_valid),
        .grant_port  (grant_port)
    );

    assign sel_we    = (grant_port == PORT_A) ? a_we    : b_we;
    assign sel_addr  = (grant_port == PORT_A) ? a_addr  : b_addr;
    assign sel_wdata = (grant_port == PORT_A) ? a_wdata : b_wdata;

    // Strobe *_d values are the levels for the state being entered, so every
    // SRAM control pin comes straight from a flop and cannot glitch.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        winner_d  = winner_q;
        wr_d      = wr_q;
        addr_d    = addr_q;
        dout_d    = dout_q;
        doe_d     = 1'b0;
        cs_n_d    = 1'b1;
        we_n_d    = 1'b1;
        oe_n_d    = 1'b1;
        a_ack_d   = 1'b0;
        b_ack_d   = 1'b0;
        a_rdata_d = a_rdata_q;
        b_rdata_d = b_rdata_q;
`ifdef RAM_ARB_RR_EN
        rr_d      = rr_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (grant_valid) begin
                    state_d  = SETUP;
                    winner_d = grant_port;
                    wr_d     = sel_we;
                    addr_d   = sel_addr;
                    dout_d   = sel_wdata;
                    cs_n_d   = 1'b0;
                    doe_d    = sel_we;
                    oe_n_d   = sel_we;
`ifdef RAM_ARB_RR_EN
                    rr_d     = grant_port;
`endif
                end
            end
            SETUP: begin
                state_d = STROBE;
                cnt_d   = '0;
                cs_n_d  = 1'b0;
                doe_d   = wr_q;
                we_n_d  = ~wr_q;
                oe_n_d  = wr_q;
            end
            STROBE: begin
                cs_n_d = 1'b0;
                doe_d  = wr_q;
                if (cnt_q == LAST_CNT) begin
                    state_d = HOLD;
                    a_ack_d = (winner_q == PORT_A);
                    b_ack_d = (winner_q == PORT_B);
                    if (!wr_q) begin
                        if (winner_q == PORT_A) a_rdata_d = ram_din;
                        else                    b_rdata_d = ram_din;
                    end
                end else begin
                    cnt_d  = cnt_q + 1'b1;
                    we_n_d = ~wr_q;
                    oe_n_d = wr_q;
                end
            end
            HOLD: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            winner_q  <= PORT_A;
            wr_q      <= 1'b0;
            addr_q    <= '0;
            dout_q    <= '0;
            doe_q     <= 1'b0;
            cs_n_q    <= 1'b1;
            we_n_q    <= 1'b1;
            oe_n_q    <= 1'b1;
            a_ack_q   <= 1'b0;
            b_ack_q   <= 1'b0;
            a_rdata_q <= '0;
            b_rdata_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            winner_q  <= winner_d;
            wr_q      <= wr_d;
            addr_q    <= addr_d;
            dout_q    <= dout_d;
            doe_q     <= doe_d;
            cs_n_q    <= cs_n_d;
            we_n_q    <= we_n_d;
            oe_n_q    <= oe_n_d;
            a_ack_q   <= a_ack_d;
            b_ack_q   <= b_ack_d;
            a_rdata_q <= a_rdata_d;
            b_rdata_q <= b_rdata_d;
        end
    end

`ifdef RAM_ARB_RR_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) rr_q <= PORT_B;
        else       rr_q <= rr_d;
    end
`endif

    assign ram_addr = addr_q;
    assign ram_dout = dout_q;
    assign ram_doe  = doe_q;
    assign ram_cs_n = cs_n_q;
    assign ram_we_n = we_n_q;
    assign ram_oe_n = oe_n_q;
    assign a_ack    = a_ack_q;
    assign b_ack    = b_ack_q;
    assign a_rdata  = a_rdata_q;
    assign b_rdata  = b_rdata_q;
    assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter: three instances (WAIT_STATES 1, 0, 3), each with an SRAM model.
// Honours RAM_ARB_RR_EN for the expected arbitration order.
module tb_ram_arbiter;

    localparam int NI = 3;
    localparam int N_RAND = 1000;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic        a_req [NI];
    logic        a_we [NI];
    logic [15:0] a_addr [NI];
    logic [7:0]  a_wdata [NI];
    logic        a_ack [NI];
    logic [7:0]  a_rdata [NI];
    logic        b_req [NI];
    logic        b_we [NI];
    logic [15:0] b_addr [NI];
    logic [7:0]  b_wdata [NI];
    logic        b_ack [NI];
    logic [7:0]  b_rdata [NI];
    logic [15:0] ram_addr [NI];
    logic [7:0]  ram_dout [NI];
    logic [7:0]  ram_din [NI];
    logic        ram_doe [NI];
    logic        ram_cs_n [NI];
    logic        ram_we_n [NI];
    logic        ram_oe_n [NI];
    logic        busy [NI];

    int checks   = 0;
    int failures = 0;
    bit last_b;  // last port served on instance 0 (1 = B)
    logic [7:0] ref_mem [int];

    for (genvar g = 0; g < NI; g++) begin : g_dut
        logic [7:0] mem [65536];
        int viol = 0;

        ram_arbiter #(
            .AW          (16),
            .DW          (8),
            .WAIT_STATES ((g == 0) ? 1 : ((g == 1) ? 0 : 3))
        ) u_dut (
            .clk      (clk),
            .reset    (reset),
            .a_req    (a_req[g]),
            .a_we     (a_we[g]),
            .a_addr   (a_addr[g]),
            .a_wdata  (a_wdata[g]),
            .a_ack    (a_ack[g]),
            .a_rdata  (a_rdata[g]),
            .b_req    (b_req[g]),
            .b_we     (b_we[g]),
            .b_addr   (b_addr[g]),
            .b_wdata  (b_wdata[g]),
            .b_ack    (b_ack[g]),
            .b_rdata  (b_rdata[g]),
            .ram_addr (ram_addr[g]),
            .ram_dout (ram_dout[g]),
            .ram_doe  (ram_doe[g]),
            .ram_din  (ram_din[g]),
            .ram_cs_n (ram_cs_n[g]),
            .ram_we_n (ram_we_n[g]),
            .ram_oe_n (ram_oe_n[g]),
            .busy     (busy[g])
        );

        // Async SRAM: drives the bus while selected and output-enabled, latches on WE rising.
        assign ram_din[g] = (!ram_cs_n[g] && !ram_oe_n[g]) ? mem[ram_addr[g]] : 8'hEE;

        initial begin
            mem[0] = 8'h3C;
            forever begin
                @(posedge ram_we_n[g]);
                if (!ram_cs_n[g] && ram_doe[g]) mem[ram_addr[g]] = ram_dout[g];
            end
        end

        always @(negedge clk) begin
            if (!reset) begin
                if (!ram_we_n[g] && !ram_oe_n[g]) begin
                    viol++;
                    if (viol < 5) $display("FAIL we_oe_overlap inst=%0d t=%0t got=both_low exp=not_both", g, $time);
                end
                if (!ram_oe_n[g] && ram_doe[g]) begin
                    viol++;
                    if (viol < 5) $display("FAIL doe_during_oe inst=%0d t=%0t got=doe1 exp=doe0", g, $time);
                end
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    task automatic drive(input int k, input int p, input bit req, input bit we,
                         input logic [15:0] addr, input logic [7:0] wd);
        if (p == 0) begin
            a_req[k] = req; a_we[k] = we; a_addr[k] = addr; a_wdata[k] = wd;
        end else begin
            b_req[k] = req; b_we[k] = we; b_addr[k] = addr; b_wdata[k] = wd;
        end
    endtask

    // One access from an idle instance; cycle n counts from the IDLE cycle that samples the request.
    task automatic do_access(input int k, input int p, input bit we, input logic [15:0] addr,
                             input logic [7:0] wd, output int lat, output int we_lo,
                             output int oe_lo, output int other_acks, output logic [7:0] rd);
        @(negedge clk);
        drive(k, p, 1'b1, we, addr, wd);
        lat = -1; we_lo = 0; oe_lo = 0; other_acks = 0; rd = 8'h00;
        for (int n = 1; n <= 30; n++) begin
            @(negedge clk);
            if (!ram_we_n[k]) we_lo++;
            if (!ram_oe_n[k]) oe_lo++;
            if ((p == 0) ? b_ack[k] : a_ack[k]) other_acks++;
            if ((p == 0) ? a_ack[k] : b_ack[k]) begin
                lat = n;
                rd  = (p == 0) ? a_rdata[k] : b_rdata[k];
                break;
            end
        end
        drive(k, p, 1'b0, 1'b0, 16'h0000, 8'h00);
        if (lat > 0 && k == 0) last_b = (p == 1);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        for (int k = 0; k < NI; k++) begin
            drive(k, 0, 1'b0, 1'b0, 16'h0000, 8'h00);
            drive(k, 1, 1'b0, 1'b0, 16'h0000, 8'h00);
        end
        repeat (2) @(negedge clk);
        for (int k = 0; k < NI; k++) begin
            checks++;
            if ({ram_cs_n[k], ram_we_n[k], ram_oe_n[k], ram_doe[k], a_ack[k], b_ack[k], busy[k]}
                !== 7'b1110000) begin
                failures++;
                $display("FAIL reset_ctrl inst=%0d got=%b exp=1110000", k,
                    {ram_cs_n[k], ram_we_n[k], ram_oe_n[k], ram_doe[k], a_ack[k], b_ack[k], busy[k]});
            end
            checks++;
            if ({ram_addr[k], ram_dout[k], a_rdata[k], b_rdata[k]} !== 40'h0) begin
                failures++;
                $display("FAIL reset_data inst=%0d got=%h exp=0", k,
                    {ram_addr[k], ram_dout[k], a_rdata[k], b_rdata[k]});
            end
        end
        reset  = 1'b0;
        last_b = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_write_read();
        int lat, we_lo, oe_lo, oth;
        logic [7:0] rd;
        do_access(0, 0, 1'b1, 16'h1234, 8'hA5, lat, we_lo, oe_lo, oth, rd);
        checks++;
        if (lat !== 4) begin failures++; $display("FAIL wr_latency got=%0d exp=4", lat); end
        checks++;
        if (we_lo !== 2) begin failures++; $display("FAIL wr_we_low got=%0d exp=2", we_lo); end
        checks++;
        if (oe_lo !== 0) begin failures++; $display("FAIL wr_oe_low got=%0d exp=0", oe_lo); end
        do_access(0, 0, 1'b0, 16'h1234, 8'h00, lat, we_lo, oe_lo, oth, rd);
        checks++;
        if (lat !== 4) begin failures++; $display("FAIL rd_latency got=%0d exp=4", lat); end
        checks++;
        if (rd !== 8'hA5) begin failures++; $display("FAIL rd_data got=%h exp=a5", rd); end
        checks++;
        if (we_lo !== 0 || oe_lo !== 3) begin
            failures++; $display("FAIL rd_strobes got=we%0d/oe%0d exp=we0/oe3", we_lo, oe_lo);
        end
    endtask

    task automatic test_b_read();
        int lat, we_lo, oe_lo, oth;
        logic [7:0] rd;
        do_access(0, 1, 1'b0, 16'h0000, 8'h00, lat, we_lo, oe_lo, oth, rd);
        checks++;
        if (lat !== 4) begin failures++; $display("FAIL b_latency got=%0d exp=4", lat); end
        checks++;
        if (rd !== 8'h3C) begin failures++; $display("FAIL b_rdata got=%h exp=3c", rd); end
        checks++;
        if (oth !== 0) begin failures++; $display("FAIL b_read_a_ack got=%0d exp=0", oth); end
    endtask

    task automatic test_contention();
        bit got [4];
        bit last, exp_b, seen;
        int cnt = 0;
        @(negedge clk);
        drive(0, 0, 1'b1, 1'b0, 16'h1234, 8'h00);
        drive(0, 1, 1'b1, 1'b0, 16'h0000, 8'h00);
        for (int n = 0; n < 60 && cnt < 4; n++) begin
            @(negedge clk);
            if (a_ack[0] || b_ack[0]) begin
                got[cnt] = b_ack[0];
                checks++;
                if ((a_ack[0] && a_rdata[0] !== 8'hA5) || (b_ack[0] && b_rdata[0] !== 8'h3C)) begin
                    failures++;
                    $display("FAIL cont_data got=%h/%h exp=a5/3c", a_rdata[0], b_rdata[0]);
                end
                cnt++;
                if (cnt == 4) begin
`ifdef RAM_ARB_RR_EN
                    drive(0, 1, 1'b0, 1'b0, 16'h0000, 8'h00);
`endif
                    drive(0, 0, 1'b0, 1'b0, 16'h0000, 8'h00);
                end
            end
        end
        drive(0, 0, 1'b0, 1'b0, 16'h0000, 8'h00);
        checks++;
        if (cnt !== 4) begin failures++; $display("FAIL cont_count got=%0d exp=4", cnt); end
        last = last_b;
        for (int i = 0; i < cnt; i++) begin
`ifdef RAM_ARB_RR_EN
            exp_b = !last;
`else
            exp_b = 1'b0;
`endif
            last = exp_b;
            checks++;
            if (got[i] !== exp_b) begin
                failures++;
                $display("FAIL cont_grant%0d got=%s exp=%s", i, got[i] ? "B" : "A", exp_b ? "B" : "A");
            end
        end
        last_b = last;
        seen = 1'b0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (b_ack[0]) begin
                seen = 1'b1;
                last_b = 1'b1;
                break;
            end
        end
        drive(0, 1, 1'b0, 1'b0, 16'h0000, 8'h00);
`ifdef RAM_ARB_RR_EN
        checks++;
        if (seen) begin failures++; $display("FAIL cont_extra_b got=ack exp=none"); end
`else
        checks++;
        if (!seen) begin failures++; $display("FAIL cont_b_after_a got=none exp=ack"); end
`endif
    endtask

    task automatic test_wait_states();
        int lat, we_lo, oe_lo, oth, ws;
        logic [7:0] rd;
        for (int k = 1; k < NI; k++) begin
            ws = (k == 1) ? 0 : 3;
            do_access(k, 0, 1'b1, 16'h0055, 8'(8'h50 + k), lat, we_lo, oe_lo, oth, rd);
            checks++;
            if (lat !== 3 + ws) begin
                failures++; $display("FAIL ws%0d_wr_latency got=%0d exp=%0d", ws, lat, 3 + ws);
            end
            checks++;
            if (we_lo !== ws + 1) begin
                failures++; $display("FAIL ws%0d_we_low got=%0d exp=%0d", ws, we_lo, ws + 1);
            end
            do_access(k, 1, 1'b0, 16'h0055, 8'h00, lat, we_lo, oe_lo, oth, rd);
            checks++;
            if (lat !== 3 + ws) begin
                failures++; $display("FAIL ws%0d_rd_latency got=%0d exp=%0d", ws, lat, 3 + ws);
            end
            checks++;
            if (rd !== 8'(8'h50 + k)) begin
                failures++; $display("FAIL ws%0d_rd_data got=%h exp=%h", ws, rd, 8'(8'h50 + k));
            end
        end
    endtask

    task automatic test_reset_mid();
        int lat, we_lo, oe_lo, oth, acks = 0;
        logic [7:0] rd;
        bit seen = 1'b0;
        @(negedge clk);
        drive(0, 0, 1'b1, 1'b1, 16'h0777, 8'h11);
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            if (!ram_we_n[0]) begin seen = 1'b1; break; end
        end
        checks++;
        if (!seen) begin failures++; $display("FAIL mid_strobe got=none exp=we_low"); end
        #1 reset = 1'b1;
        #1;
        checks++;
        if ({ram_cs_n[0], ram_we_n[0], ram_oe_n[0], ram_doe[0], busy[0]} !== 5'b11100) begin
            failures++;
            $display("FAIL mid_reset_release got=%b exp=11100",
                {ram_cs_n[0], ram_we_n[0], ram_oe_n[0], ram_doe[0], busy[0]});
        end
        drive(0, 0, 1'b0, 1'b0, 16'h0000, 8'h00);
        last_b = 1'b1;
        @(negedge clk);
        if (a_ack[0]) acks++;
        reset = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (a_ack[0] || b_ack[0]) acks++;
        end
        checks++;
        if (acks !== 0) begin failures++; $display("FAIL mid_no_ack got=%0d exp=0", acks); end
        do_access(0, 0, 1'b1, 16'h0777, 8'h66, lat, we_lo, oe_lo, oth, rd);
        do_access(0, 0, 1'b0, 16'h0777, 8'h00, lat, we_lo, oe_lo, oth, rd);
        checks++;
        if (lat !== 4 || rd !== 8'h66) begin
            failures++; $display("FAIL mid_after got=lat%0d/%h exp=lat4/66", lat, rd);
        end
    endtask

    task automatic test_random();
        bit         pend [2];
        bit         we_r [2];
        logic [15:0] addr_r [2];
        logic [7:0]  wd_r [2];
        int         wait_c [2];
        int         done [2];
        int         acked [2];
        logic       ack;
        logic [7:0] rdv;
        for (int p = 0; p < 2; p++) begin
            pend[p] = 1'b0; done[p] = 0; acked[p] = 0; wait_c[p] = 0;
        end
        for (int cyc = 0; cyc < 60000 && (done[0] < N_RAND || done[1] < N_RAND); cyc++) begin
            @(negedge clk);
            for (int p = 0; p < 2; p++) begin
                ack = (p == 0) ? a_ack[0] : b_ack[0];
                rdv = (p == 0) ? a_rdata[0] : b_rdata[0];
                if (ack) begin
                    checks++;
                    if (!pend[p]) begin
                        failures++; $display("FAIL rand_spurious_ack port=%0d got=ack exp=none", p);
                    end else if (!we_r[p] && ref_mem.exists(int'(addr_r[p]))
                                 && rdv !== ref_mem[int'(addr_r[p])]) begin
                        failures++;
                        $display("FAIL rand_read port=%0d addr=%h got=%h exp=%h", p, addr_r[p], rdv,
                            ref_mem[int'(addr_r[p])]);
                    end
                    if (pend[p]) begin
                        if (we_r[p]) ref_mem[int'(addr_r[p])] = wd_r[p];
                        pend[p] = 1'b0;
                        done[p]++;
                        acked[p]++;
                        drive(0, p, 1'b0, 1'b0, 16'h0000, 8'h00);
                    end
                end else if (pend[p]) begin
                    wait_c[p]++;
                    if (wait_c[p] > 400) begin
                        checks++; failures++;
                        $display("FAIL rand_timeout port=%0d got=no_ack exp=ack", p);
                        pend[p] = 1'b0;
                        done[p]++;
                        drive(0, p, 1'b0, 1'b0, 16'h0000, 8'h00);
                    end
                end
            end
            for (int p = 0; p < 2; p++) begin
                if (!pend[p] && done[p] < N_RAND && $urandom_range(0, 1) == 1) begin
                    we_r[p]   = 1'($urandom_range(0, 1));
                    addr_r[p] = 16'(32'h8000 + $urandom_range(0, 15));
                    wd_r[p]   = 8'($urandom);
                    pend[p]   = 1'b1;
                    wait_c[p] = 0;
                    drive(0, p, 1'b1, we_r[p], addr_r[p], wd_r[p]);
                end
            end
        end
        checks++;
        if (acked[0] !== N_RAND || acked[1] !== N_RAND) begin
            failures++;
            $display("FAIL rand_ack_count got=%0d/%0d exp=%0d/%0d", acked[0], acked[1], N_RAND, N_RAND);
        end
    endtask

    task automatic test_invariants();
        checks++;
        if (g_dut[0].viol !== 0) begin failures++; $display("FAIL inv_inst0 got=%0d exp=0", g_dut[0].viol); end
        checks++;
        if (g_dut[1].viol !== 0) begin failures++; $display("FAIL inv_inst1 got=%0d exp=0", g_dut[1].viol); end
        checks++;
        if (g_dut[2].viol !== 0) begin failures++; $display("FAIL inv_inst2 got=%0d exp=0", g_dut[2].viol); end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_b_read();
        test_contention();
        test_wait_states();
        test_reset_mid();
        test_random();
        test_invariants();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
